ahb_burst_ram_sub: RTL and testbench



---
 rtl/ahb_burst_ram_sub.sv | 188 ++++++++++++++++++
 tb/tb_ahb_burst_ram_sub.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_ram_sub.sv
// ahb_burst_ram_sub: AHB-Lite subordinate in front of a word-organised RAM.
// NONSEQ transfers pay LATENCY address-phase wait states; SEQ beats inside a
// burst complete with zero waits when BURST_EN=1. Writes honour HWSTRB byte
// lanes. A read accepted on the same edge a write commits to the same word
// returns the merged data.
// Optional build macro: AHB_RAM_ERR_RESP_EN. When it is defined, out-of-range or
// misaligned accesses get a two-cycle ERROR response. When it is undefined,
// HRESP is tied to 0 and out-of-range addresses wrap onto the array.
// The array depth is assumed to be a power of two, because RANGE is a byte mask.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transfer in its data phase, HREADYOUT=1
// WAIT  | inserting wait states for an accepted transfer, HREADYOUT=0
// DATA  | data phase completing, HREADYOUT=1, write commits on HREADY
// ERR1  | first ERROR cycle, HREADYOUT=0, HRESP=1 (optional)
// ERR2  | second ERROR cycle, HREADYOUT=1, HRESP=1 (optional)

module ahb_burst_ram_sub #(
  parameter int          AHBW     = 32,
  parameter int          PA_BITS  = 32,
  parameter int unsigned RANGE    = 32'h1FF,
  parameter int          LATENCY  = 0,
  parameter int          BURST_EN = 1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [PA_BITS-1:0]  HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic                HREADY,
  input  logic [AHBW-1:0]     HWDATA,
  input  logic [AHBW/8-1:0]   HWSTRB,
  output logic [AHBW-1:0]     HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP
);

  localparam int BYTES     = AHBW / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int DEPTH     = int'((RANGE + 1) / BYTES);
  localparam int IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
`ifdef AHB_RAM_ERR_RESP_EN
    , S_ERR1,
    S_ERR2
`endif
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [IDX_BITS-1:0]   addr_q;
  logic                  write_q;
  logic                  hreadyout_q;
  logic [AHBW-1:0]       hrdata_q;

  logic [AHBW-1:0]       mem [DEPTH];

  logic                  accept;
  logic                  acc_wait;
  logic [IDX_BITS-1:0]   acc_idx;
  logic                  commit;
  logic [IDX_BITS-1:0]   rd_idx;
  logic [AHBW-1:0]       wr_merged;
  logic [AHBW-1:0]       rd_word;
  logic                  unused_bits;

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign acc_idx  = HADDR[IDX_BITS+LANE_BITS-1:LANE_BITS];
  // SEQ beats skip the wait states only when bursting is enabled.
  assign acc_wait = (LATENCY > 0) && (!HTRANS[0] || (BURST_EN == 0));
  assign commit   = (state_q == S_DATA) && HREADY && write_q;

  // HBURST is informational and only part of HADDR selects the word.
  assign unused_bits = ^{HBURST, HSIZE, HADDR};

`ifdef AHB_RAM_ERR_RESP_EN
  logic       hresp_q;
  logic [6:0] size_mask;
  logic       acc_err;

  // Flag accesses that fall outside the region or are misaligned to HSIZE.
  always_comb begin
    size_mask = 7'((8'd1 << HSIZE) - 8'd1);
    acc_err   = (|(HADDR & ~PA_BITS'(RANGE)))
             || (|(HADDR[6:0] & size_mask))
             || (int'(HSIZE) > LANE_BITS);
  end

  assign HRESP = hresp_q;
`else
  assign HRESP = 1'b0;
`endif

  // Merge the committing write's enabled lanes over the stored word.
  always_comb begin
    wr_merged = mem[addr_q];
    for (int i = 0; i < BYTES; i++) begin
      if (HWSTRB[i]) wr_merged[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // Word to load into HRDATA on the edge entering DATA, forwarding a same-edge write.
  always_comb begin
    rd_idx  = (state_q == S_WAIT) ? addr_q : acc_idx;
    rd_word = (commit && (rd_idx == addr_q)) ? wr_merged : mem[rd_idx];
  end

  // Byte-lane array write at the completing edge of a write data phase.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (HWSTRB[i]) mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Transfer FSM with registered HREADYOUT/HRESP/HRDATA.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hrdata_q    <= '0;
`ifdef AHB_RAM_ERR_RESP_EN
      hresp_q     <= 1'b0;
`endif
    end else if (state_q == S_WAIT) begin
      if (cnt_q == 4'd0) begin
        state_q     <= S_DATA;
        hreadyout_q <= 1'b1;
        if (!write_q) hrdata_q <= rd_word;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
`ifdef AHB_RAM_ERR_RESP_EN
    else if (state_q == S_ERR1) begin
      state_q     <= S_ERR2;
      hreadyout_q <= 1'b1;
    end
`endif
    else if (!HREADY && (state_q != S_IDLE)) begin
      // Data phase stretched by another agent: hold everything.
      state_q <= state_q;
    end else if (accept) begin
      addr_q  <= acc_idx;
      write_q <= HWRITE;
`ifdef AHB_RAM_ERR_RESP_EN
      hresp_q <= acc_err;
      if (acc_err) begin
        state_q     <= S_ERR1;
        hreadyout_q <= 1'b0;
        write_q     <= 1'b0;
      end else
`endif
      if (acc_wait) begin
        state_q     <= S_WAIT;
        cnt_q       <= LAT_M1;
        hreadyout_q <= 1'b0;
      end else begin
        state_q     <= S_DATA;
        hreadyout_q <= 1'b1;
        if (!HWRITE) hrdata_q <= rd_word;
      end
    end else begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
`ifdef AHB_RAM_ERR_RESP_EN
      hresp_q     <= 1'b0;
`endif
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_burst_ram_sub.sv
// Bench for ahb_burst_ram_sub: two instances (LATENCY=0 and LATENCY=3) share
// one pipelined AHB driver. A byte-lane memory model predicts read data, which
// is queued at address-phase issue and compared when the data phase completes.
`timescale 1ns/1ps

module tb_ahb_burst_ram_sub;

  localparam int          AHBW    = 32;
  localparam int          PA_BITS = 32;
  localparam int unsigned RANGE   = 32'h1FF;
`ifdef AHB_RAM_ERR_RESP_EN
  localparam logic [31:0] BASE = 32'h0000_0000;
`else
  localparam logic [31:0] BASE = 32'h0000_2000;
`endif
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL0, HSEL1;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic [31:0] hrdata0, hrdata1;
  logic        hrdy0, hrdy1, hresp0, hresp1;
  logic        sel;
  logic [31:0] HRDATA;
  logic        HRESP;

  assign HREADY = sel ? hrdy1 : hrdy0;
  assign HRDATA = sel ? hrdata1 : hrdata0;
  assign HRESP  = sel ? hresp1 : hresp0;

  always #5 HCLK = ~HCLK;

  ahb_burst_ram_sub #(.AHBW(AHBW), .PA_BITS(PA_BITS), .RANGE(RANGE), .LATENCY(0), .BURST_EN(1)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(HREADY), .HWDATA(HWDATA),
    .HWSTRB(HWSTRB), .HRDATA(hrdata0), .HREADYOUT(hrdy0), .HRESP(hresp0)
  );

  ahb_burst_ram_sub #(.AHBW(AHBW), .PA_BITS(PA_BITS), .RANGE(RANGE), .LATENCY(3), .BURST_EN(1)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(HREADY), .HWDATA(HWDATA),
    .HWSTRB(HWSTRB), .HRDATA(hrdata1), .HREADYOUT(hrdy1), .HRESP(hresp1)
  );

  int          n_checks;
  int          n_errors;
  logic [31:0] tx_addr  [8];
  logic [31:0] tx_wdata [8];
  logic        tx_wr    [8];
  logic [1:0]  tx_trans [8];
  logic [3:0]  tx_strb  [8];
  logic [31:0] model [2][128];
  logic [31:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_beat(input int i, input logic [31:0] addr, input logic wr,
                          input logic [1:0] trans, input logic [31:0] wdata, input logic [3:0] strb);
    tx_addr[i]  = addr;
    tx_wr[i]    = wr;
    tx_trans[i] = trans;
    tx_wdata[i] = wdata;
    tx_strb[i]  = strb;
  endtask

  // Apply a write to the model, or queue the expected data for a read.
  task automatic model_issue(input int k);
    int idx;
    idx = int'((tx_addr[k] >> 2) & 32'h7F);
    if (tx_wr[k]) begin
      for (int i = 0; i < 4; i++)
        if (tx_strb[k][i]) model[sel][idx][8*i +: 8] = tx_wdata[k][8*i +: 8];
    end else begin
      exp_q.push_back(model[sel][idx]);
    end
  endtask

  // Pipelined AHB driver: address phase of beat k overlaps data phase of beat k-1.
  task automatic run_seq(input string tag, input int n, output int waits, output int dcyc);
    int          k, dp, last_k, guard;
    logic        rdy;
    bit          done;
    logic [31:0] exp;
    k = 0; dp = -1; last_k = -1; guard = 0; done = 0; waits = 0; dcyc = 0;
    while (!done) begin
      if (k < n) begin
        if (k != last_k) begin
          model_issue(k);
          last_k = k;
        end
        HSEL0  = (sel == 1'b0);
        HSEL1  = (sel == 1'b1);
        HADDR  = tx_addr[k];
        HWRITE = tx_wr[k];
        HTRANS = tx_trans[k];
      end else begin
        HSEL0 = 1'b0; HSEL1 = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0;
      end
      if (dp >= 0) begin
        HWDATA = tx_wdata[dp];
        HWSTRB = tx_strb[dp];
      end
      @(negedge HCLK);
      rdy = HREADY;
      if (dp >= 0) begin
        dcyc++;
        if (!rdy) waits++;
        else begin
          check_val({tag, "_hresp"}, {31'd0, HRESP}, 32'd0);
          if (!tx_wr[dp]) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            check_val(tag, HRDATA, exp);
          end
        end
      end
      @(posedge HCLK); #1;
      if (rdy) begin
        if (k < n) begin
          dp = k;
          k++;
        end else begin
          done = 1;
        end
      end
      guard++;
      if (guard > 100) begin
        check_val({tag, "_timeout"}, guard, 0);
        done = 1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish by 200000ns");
    $fatal(1);
  end

  initial begin
    int w, d;
    n_checks = 0; n_errors = 0; sel = 1'b0;
    HRESETn = 1'b0; HSEL0 = 1'b0; HSEL1 = 1'b0; HADDR = '0; HTRANS = T_IDLE;
    HWRITE = 1'b0; HSIZE = 3'b010; HBURST = 3'b000; HWDATA = '0; HWSTRB = '0;
    repeat (3) @(posedge HCLK);
    #1;
    check_val("rst_rdy0",   {31'd0, hrdy0},  32'd1);
    check_val("rst_resp0",  {31'd0, hresp0}, 32'd0);
    check_val("rst_rdata0", hrdata0,         32'd0);
    check_val("rst_rdy1",   {31'd0, hrdy1},  32'd1);
    check_val("rst_resp1",  {31'd0, hresp1}, 32'd0);
    check_val("rst_rdata1", hrdata1,         32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // LATENCY=0: separate write then read, no wait states.
    sel = 1'b0;
    set_beat(0, BASE + 32'h4, 1'b1, T_NSEQ, 32'hDEADBEEF, 4'hF);
    run_seq("wr_dead", 1, w, d);
    check_val("lat0_wr_waits", w, 0);
    set_beat(0, BASE + 32'h4, 1'b0, T_NSEQ, 32'h0, 4'h0);
    run_seq("rd_dead", 1, w, d);
    check_val("lat0_rd_waits", w, 0);
    check_val("lat0_rd_cycles", d, 1);

    // Pipelined full write, lane write, and read of the same word (forwarding).
    set_beat(0, BASE + 32'h20, 1'b1, T_NSEQ, 32'h11223344, 4'hF);
    set_beat(1, BASE + 32'h20, 1'b1, T_NSEQ, 32'hAABBCCDD, 4'b0101);
    set_beat(2, BASE + 32'h20, 1'b0, T_NSEQ, 32'h0, 4'h0);
    run_seq("fwd_lane", 3, w, d);
    check_val("fwd_lane_waits", w, 0);
    set_beat(0, BASE + 32'h20, 1'b0, T_NSEQ, 32'h0, 4'h0);
    run_seq("lane_rd", 1, w, d);

    // LATENCY=3: INCR4 write and read pay waits only on the first beat.
    sel = 1'b1; HBURST = 3'b011;
    for (int i = 0; i < 4; i++)
      set_beat(i, BASE + 32'h10 + 32'(4*i), 1'b1, (i == 0) ? T_NSEQ : T_SEQ, 32'hA0A0_0000 + 32'(i), 4'hF);
    run_seq("burst_wr", 4, w, d);
    check_val("burst_wr_waits", w, 3);
    check_val("burst_wr_cycles", d, 7);
    HBURST = 3'b000;
    set_beat(0, BASE + 32'h14, 1'b0, T_NSEQ, 32'h0, 4'h0);
    run_seq("single_rd", 1, w, d);
    check_val("single_rd_waits", w, 3);
    check_val("single_rd_cycles", d, 4);
    HBURST = 3'b011;
    for (int i = 0; i < 4; i++)
      set_beat(i, BASE + 32'h10 + 32'(4*i), 1'b0, (i == 0) ? T_NSEQ : T_SEQ, 32'h0, 4'h0);
    run_seq("burst_rd", 4, w, d);
    check_val("burst_rd_waits", w, 3);
    check_val("burst_rd_cycles", d, 7);
    HBURST = 3'b000;

    // Reset during the wait states of a write: write dropped, outputs reset at once.
    set_beat(0, BASE + 32'h40, 1'b1, T_NSEQ, 32'h01234567, 4'hF);
    run_seq("rst_old", 1, w, d);
    HSEL1 = 1'b1; HADDR = BASE + 32'h40; HTRANS = T_NSEQ; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HSEL1 = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0; HWDATA = 32'hFFFF_FFFF; HWSTRB = 4'hF;
    @(negedge HCLK);
    check_val("rst_in_wait", {31'd0, hrdy1}, 32'd0);
    #1 HRESETn = 1'b0;
    #1;
    check_val("rst_async_rdy", {31'd0, hrdy1}, 32'd1);
    check_val("rst_async_rdata", hrdata1, 32'd0);
    @(negedge HCLK);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    set_beat(0, BASE + 32'h40, 1'b0, T_NSEQ, 32'h0, 4'h0);
    run_seq("rst_keep", 1, w, d);

    // Out-of-range write: ERROR response, or wrap onto word 0.
    sel = 1'b0;
    set_beat(0, BASE, 1'b1, T_NSEQ, 32'h5A5A5A5A, 4'hF);
    run_seq("w0_init", 1, w, d);
`ifdef AHB_RAM_ERR_RESP_EN
    HSEL0 = 1'b1; HADDR = BASE + RANGE + 1; HTRANS = T_NSEQ; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HSEL0 = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0; HWDATA = 32'hCAFEF00D; HWSTRB = 4'hF;
    @(negedge HCLK);
    check_val("err1_rdy",  {31'd0, hrdy0},  32'd0);
    check_val("err1_resp", {31'd0, hresp0}, 32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check_val("err2_rdy",  {31'd0, hrdy0},  32'd1);
    check_val("err2_resp", {31'd0, hresp0}, 32'd1);
    @(posedge HCLK); #1;
`else
    set_beat(0, BASE + RANGE + 1, 1'b1, T_NSEQ, 32'hCAFEF00D, 4'hF);
    run_seq("wrap_wr", 1, w, d);
`endif
    set_beat(0, BASE, 1'b0, T_NSEQ, 32'h0, 4'h0);
    run_seq("w0_read", 1, w, d);

    // Random pipelined traffic over words 16..23 after initialising them.
    for (int i = 0; i < 8; i++)
      set_beat(i, BASE + 32'h40 + 32'(4*i), 1'b1, T_NSEQ, $urandom, 4'hF);
    run_seq("rnd_init", 8, w, d);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++)
        set_beat(i, BASE + 32'h40 + 32'(4*$urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 T_NSEQ, $urandom, 4'($urandom_range(0, 15)));
      run_seq("rnd", 8, w, d);
      check_val("rnd_waits", w, 0);
    end

    check_val("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
